// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core data bus.
// Stores fill a byte FIFO; a combinational status word supports polling.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h20,
  parameter logic [31:0] STATUS_ADDR  = 32'h24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic        bus_sel,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT =
    CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [7:0]    shreg;
  logic [7:0]    shreg_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [BW-1:0] baud_inc;
  logic          baud_last;
  logic          tx_d;

  logic hit_tx;
  logic hit_st;
  logic push_req;
  logic push;
  logic pop;
  logic empty;
  logic full;
  logic ovf_set;
  logic ovf_clr;
  logic [31:0] status;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  // Bus decode
  assign hit_tx   = bus_addr == TX_ADDR;
  assign hit_st   = bus_addr == STATUS_ADDR;
  assign bus_sel  = hit_tx | hit_st;
  assign push_req = bus_we & hit_tx;
  assign ovf_clr  = bus_we & hit_st
                  & bus_wdata[2];

  // FIFO flags; a pop at the same edge frees a slot
  assign empty   = count == '0;
  assign full    = count == FULL_CNT;
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  assign tx_busy = ~empty | (state_q != IDLE);

  assign status = {
    16'h0000,
    8'(count),
    4'h0,
    empty,
    overflow,
    full,
    tx_busy
  };

  assign bus_rdata = hit_st ? status : '0;

  assign baud_last = baud_q == BAUD_LAST;
  assign baud_inc  = baud_last ? '0
                   : baud_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tx_d    = uart_tx;
    pop     = 1'b0;
    baud_d  = baud_inc;
    bit_d   = bit_q;
    shreg_d = shreg;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          shreg_d = {1'b0, shreg[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          // chain straight into the next start bit
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = mem[rd_ptr];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      uart_tx <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      uart_tx <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg   <= shreg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers define validity
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus_wdata[7:0];
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data bus, downstream of the core's store path. The core's writes to the TX data address are captured into a byte FIFO and serialized as 8N1 frames on `uart_tx`. A status word is returned combinationally on reads, so the core can poll it within its single-cycle load.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥2.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Power of two, ≥2.
- `TX_ADDR`, default 32'h20: byte write address.
- `STATUS_ADDR`, default 32'h24: status read/clear address.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bus_addr`  in  32  core data address (`dmem_addr`).
- `bus_wdata`  in  32  core store data.
- `bus_we`  in  1  core store strobe; sampled at posedge.
- `bus_sel`  out  1  combinational: `bus_addr` equals `TX_ADDR` or `STATUS_ADDR`. Upstream uses it to mux `bus_rdata` and suppress the RAM write.
- `bus_rdata`  out  32  combinational: status word when `bus_addr==STATUS_ADDR`, else 0.
- `uart_tx`  out  1  serial output, idle high.
- `tx_busy`  out  1  FIFO non-empty or state≠IDLE.

## Operation
- **Push:** `bus_we && bus_addr==TX_ADDR` at a posedge writes `bus_wdata[7:0]` into the FIFO; bits [31:8] are ignored.
  - If FIFO is full and no pop occurs at the same edge: byte dropped, `overflow` set (sticky).
  - Full with a simultaneous pop: push accepted, count unchanged.
- **Clear:** `bus_we && bus_addr==STATUS_ADDR && bus_wdata[2]` clears `overflow`. If a set and a clear happen at the same edge, set wins.
- **Status word:** [0] `tx_busy`, [1] full, [2] `overflow`, [3] empty, [15:8] FIFO count (zero-extended), all other bits 0.
- **FSM** (IDLE, START, DATA, STOP):
  - IDLE: on FIFO non-empty, pop into shift register → START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles → DATA.
  - DATA: 8 bits, LSB first, each `CLKS_PER_BIT` cycles. Bit index 0..7; after bit 7 → STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles. At the last cycle, if the FIFO is non-empty, pop → START directly with no idle gap; else → IDLE.
- `uart_tx` is registered (glitch-free). It is 1 in IDLE and STOP.
- **Counters:** baud counter counts 0..`CLKS_PER_BIT`-1 and wraps. FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. Count is log2(`FIFO_DEPTH`)+1 bits.
- **Reset values:** `uart_tx`=1, `tx_busy`=0, FIFO empty, `overflow`=0, state IDLE, counters 0. `bus_sel`/`bus_rdata` are combinational; status reads 32'h0000_0008 after reset.
- **Reset mid-frame:** `uart_tx` goes high asynchronously, the frame is aborted, and the FIFO is flushed.

## Timing
- Push at edge N: count increments after N; status reflects it from the cycle after N.
- From IDLE, pop occurs at edge N+1. `uart_tx` falls after N+1, so the start bit begins 1 cycle after the write edge.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- `tx_busy` falls after the last STOP cycle, only when the FIFO is empty.
- Reads have zero latency: `bus_rdata` is valid in the same cycle as `bus_addr`.

## Test plan
Parameters for all scenarios: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
1. **Reset/idle:** after reset, read 32'h24 → `bus_rdata`=32'h0000_0008, `uart_tx`=1, `tx_busy`=0.
2. **Single byte:** store 32'hFFFF_FFA5 to 32'h20 → `uart_tx`=0 from 1 cycle after the write for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop bit 1 for 4 cycles. `tx_busy` falls 40 cycles after the start bit begins.
3. **Back-to-back:** store 8'h55, 8'h0F in consecutive cycles → two 40-cycle frames with no idle gap between them. Status count reads 1 during the first frame, 0 during the second.
4. **Overflow:** store 6 bytes in consecutive cycles while the first frame starts → 1 byte popped and 4 stored, last byte dropped, status = full, `overflow`=1, count=4. Store 32'h4 to 32'h24 → `overflow`=0.
5. **Full with simultaneous pop:** FIFO full, store at the STOP→START pop edge → byte accepted, count stays 4, `overflow` stays 0.
6. **Reset mid-frame:** assert `rst_n` low during DATA bit 3 → `uart_tx`=1 immediately. After release, status=32'h0000_0008 and no further frame is sent.
